// File: rtl/jtag_dr_controller_if.sv
// Signal bundle between the TAP state machine (master) and jtag_dr_controller (slave).
// USER_DR_EN adds the USER data-register ports.
interface jtag_dr_controller_if #(
  parameter int IR_WIDTH = 4
`ifdef USER_DR_EN
  , parameter int USER_WIDTH = 8
`endif
);
  // No valid/ready: the slave samples tap_state and tdi on every rising tck.
  // tdo and tdo_en are valid in the same cycle as the ShiftIr/ShiftDr state.
  // abort and user_update are single-cycle pulses.
  logic [4:0]          tap_state;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic [IR_WIDTH-1:0] ir_value;
  logic                abort;
  logic [5:0]          dr_bit_count;
`ifdef USER_DR_EN
  logic [USER_WIDTH-1:0] user_reg;
  logic                  user_update;

  modport master (output tap_state, tdi,
                  input  tdo, tdo_en, ir_value, abort, dr_bit_count, user_reg, user_update);
  modport slave  (input  tap_state, tdi,
                  output tdo, tdo_en, ir_value, abort, dr_bit_count, user_reg, user_update);
`else
  modport master (output tap_state, tdi,
                  input  tdo, tdo_en, ir_value, abort, dr_bit_count);
  modport slave  (input  tap_state, tdi,
                  output tdo, tdo_en, ir_value, abort, dr_bit_count);
`endif
endinterface

// File: rtl/jtag_dr_controller.sv
// JTAG IR/DR controller: IR shift/update, instruction decode, IDCODE/BYPASS/USER DR sequencing.
// Optional USER data register is built when macro USER_DR_EN is defined.
module jtag_dr_controller #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h000F_AF01,
  parameter int          USER_WIDTH   = 8
) (
  input  logic tck,
  input  logic trst,
  jtag_dr_controller_if.slave bus
);

  typedef enum logic [4:0] {
    TEST_LOGIC_RESET = 5'h00,
    CAPTURE_DR       = 5'h04,
    CAPTURE_IR       = 5'h05,
    SHIFT_DR         = 5'h06,
    SHIFT_IR         = 5'h07,
    UPDATE_DR        = 5'h14,
    UPDATE_IR        = 5'h15
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_IDCODE = 2'd0,
    SEL_BYPASS = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(4'b1110);
  localparam logic [IR_WIDTH-1:0] IR_ABORT  = IR_WIDTH'(4'b1000);
`ifdef USER_DR_EN
  localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(4'b0010);
`endif

  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_value;
  logic [31:0]         dr_shift;
  logic                bypass_q;
  logic [5:0]          dr_bit_count;
  logic                abort_q;
  dr_sel_e             dr_sel;

  // Every code that is not explicitly decoded (ABORT included) selects BYPASS.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_value == IR_IDCODE) dr_sel = SEL_IDCODE;
`ifdef USER_DR_EN
    else if (ir_value == IR_USER) dr_sel = SEL_USER;
`endif
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_shift     <= '0;
      ir_value     <= IR_IDCODE;
      dr_shift     <= '0;
      bypass_q     <= 1'b0;
      dr_bit_count <= '0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (bus.tap_state)
        TEST_LOGIC_RESET: ir_value <= IR_IDCODE;
        CAPTURE_IR:       ir_shift <= IR_WIDTH'(2'b01);
        SHIFT_IR:         ir_shift <= {bus.tdi, ir_shift[IR_WIDTH-1:1]};
        UPDATE_IR: begin
          ir_value <= ir_shift;
          abort_q  <= (ir_shift == IR_ABORT);
        end
        CAPTURE_DR: begin
          dr_bit_count <= '0;
          case (dr_sel)
            SEL_IDCODE: dr_shift <= IDCODE_VALUE;
`ifdef USER_DR_EN
            SEL_USER:   dr_shift[USER_WIDTH-1:0] <= bus.user_reg;
`endif
            default:    bypass_q <= 1'b0;
          endcase
        end
        SHIFT_DR: begin
          if (dr_bit_count != 6'd63) dr_bit_count <= dr_bit_count + 6'd1;
          case (dr_sel)
            SEL_IDCODE: dr_shift <= {bus.tdi, dr_shift[31:1]};
`ifdef USER_DR_EN
            SEL_USER:   dr_shift[USER_WIDTH-1:0] <= {bus.tdi, dr_shift[USER_WIDTH-1:1]};
`endif
            default:    bypass_q <= bus.tdi;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef USER_DR_EN
  logic [USER_WIDTH-1:0] user_reg;
  logic                  user_update;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      user_reg    <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (bus.tap_state == UPDATE_DR && dr_sel == SEL_USER) begin
        user_reg    <= dr_shift[USER_WIDTH-1:0];
        user_update <= 1'b1;
      end
    end
  end

  assign bus.user_reg    = user_reg;
  assign bus.user_update = user_update;
`else
  logic unused_user_width;
  assign unused_user_width = (USER_WIDTH > 0);
`endif

  // tdo is combinational so the first captured bit appears in the first shift cycle.
  always_comb begin
    bus.tdo    = 1'b0;
    bus.tdo_en = 1'b0;
    if (!trst) begin
      if (bus.tap_state == SHIFT_IR) begin
        bus.tdo    = ir_shift[0];
        bus.tdo_en = 1'b1;
      end else if (bus.tap_state == SHIFT_DR) begin
        bus.tdo    = (dr_sel == SEL_BYPASS) ? bypass_q : dr_shift[0];
        bus.tdo_en = 1'b1;
      end
    end
  end

  assign bus.ir_value     = ir_value;
  assign bus.abort        = abort_q;
  assign bus.dr_bit_count = dr_bit_count;

endmodule

// File: tb/tb_jtag_dr_controller.sv
// Directed self-checking bench for jtag_dr_controller (default build and USER_DR_EN build).
module tb_jtag_dr_controller;

  localparam logic [4:0] S_TLR   = 5'h00;
  localparam logic [4:0] S_RTI   = 5'h01;
  localparam logic [4:0] S_CDR   = 5'h04;
  localparam logic [4:0] S_CIR   = 5'h05;
  localparam logic [4:0] S_SDR   = 5'h06;
  localparam logic [4:0] S_SIR   = 5'h07;
  localparam logic [4:0] S_PAUSE = 5'h03;
  localparam logic [4:0] S_UDR   = 5'h14;
  localparam logic [4:0] S_UIR   = 5'h15;

  logic tck;
  logic trst;
  logic tdo_s;
  logic tdo_en_s;
  int   n_checks;
  int   n_fail;

  jtag_dr_controller_if #(
    .IR_WIDTH(4)
`ifdef USER_DR_EN
    , .USER_WIDTH(8)
`endif
  ) bus ();

  jtag_dr_controller #(
    .IR_WIDTH(4),
    .IDCODE_VALUE(32'h000F_AF01),
    .USER_WIDTH(8)
  ) dut (
    .tck(tck),
    .trst(trst),
    .bus(bus.slave)
  );

  // clock / reset
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // driver: present one TAP state for one cycle, sample tdo mid-cycle
  task automatic step(input logic [4:0] st, input logic d);
    bus.tap_state = st;
    bus.tdi       = d;
    @(negedge tck);
    tdo_s    = bus.tdo;
    tdo_en_s = bus.tdo_en;
    @(posedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] code);
    step(S_CIR, 1'b0);
    for (int i = 0; i < 4; i++) step(S_SIR, code[i]);
    step(S_UIR, 1'b0);
  endtask

  task automatic test_reset;
    trst          = 1'b1;
    bus.tap_state = S_SIR;
    bus.tdi       = 1'b1;
    repeat (2) @(posedge tck);
    #1;
    n_checks++; if (bus.ir_value !== 4'b1110) begin n_fail++; $display("FAIL reset_ir_value: got %h expected e", bus.ir_value); end
    n_checks++; if (bus.tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b expected 0", bus.tdo); end
    n_checks++; if (bus.tdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_en: got %b expected 0", bus.tdo_en); end
    n_checks++; if (bus.abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", bus.abort); end
    n_checks++; if (bus.dr_bit_count !== 6'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d expected 0", bus.dr_bit_count); end
`ifdef USER_DR_EN
    n_checks++; if (bus.user_reg !== 8'h00) begin n_fail++; $display("FAIL reset_user_reg: got %h expected 00", bus.user_reg); end
    n_checks++; if (bus.user_update !== 1'b0) begin n_fail++; $display("FAIL reset_user_update: got %b expected 0", bus.user_update); end
`endif
    bus.tap_state = S_RTI;
    trst          = 1'b0;
    step(S_RTI, 1'b0);
  endtask

  task automatic test_idcode;
    logic [31:0] seq;
    logic        en_ok;
    seq   = '0;
    en_ok = 1'b1;
    step(S_CDR, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(S_SDR, 1'b0);
      seq[i] = tdo_s;
      if (tdo_en_s !== 1'b1) en_ok = 1'b0;
    end
    step(S_RTI, 1'b0);
    n_checks++; if (seq !== 32'h000F_AF01) begin n_fail++; $display("FAIL idcode_tdo: got %h expected 000faf01", seq); end
    n_checks++; if (en_ok !== 1'b1) begin n_fail++; $display("FAIL idcode_tdo_en: got low expected high during shift"); end
    n_checks++; if (bus.dr_bit_count !== 6'd32) begin n_fail++; $display("FAIL idcode_bit_count: got %0d expected 32", bus.dr_bit_count); end
    n_checks++; if (tdo_en_s !== 1'b0) begin n_fail++; $display("FAIL idle_tdo_en: got %b expected 0", tdo_en_s); end
  endtask

  task automatic test_ir;
    logic [3:0] seq;
    step(S_CIR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(S_SIR, 1'b1);
      seq[i] = tdo_s;
    end
    n_checks++; if (bus.ir_value !== 4'b1110) begin n_fail++; $display("FAIL ir_before_update: got %h expected e", bus.ir_value); end
    step(S_UIR, 1'b0);
    n_checks++; if (seq !== 4'b0001) begin n_fail++; $display("FAIL ir_capture_tdo: got %b expected 0001", seq); end
    n_checks++; if (bus.ir_value !== 4'b1111) begin n_fail++; $display("FAIL ir_update: got %h expected f", bus.ir_value); end
    n_checks++; if (bus.abort !== 1'b0) begin n_fail++; $display("FAIL ir_no_abort: got %b expected 0", bus.abort); end
  endtask

  task automatic bypass_scan(input string name);
    logic [3:0] seq;
    logic [3:0] din;
    din = 4'b1101;
    step(S_CDR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(S_SDR, din[i]);
      seq[i] = tdo_s;
    end
    step(S_RTI, 1'b0);
    n_checks++; if (seq !== 4'b1010) begin n_fail++; $display("FAIL %s_tdo: got %b expected 1010", name, seq); end
    n_checks++; if (bus.dr_bit_count !== 6'd4) begin n_fail++; $display("FAIL %s_bit_count: got %0d expected 4", name, bus.dr_bit_count); end
  endtask

  task automatic test_bypass;
    bypass_scan("bypass");
    load_ir(4'b0101);
    n_checks++; if (bus.ir_value !== 4'b0101) begin n_fail++; $display("FAIL unknown_ir_value: got %h expected 5", bus.ir_value); end
    bypass_scan("unknown_ir");
`ifndef USER_DR_EN
    load_ir(4'b0010);
    bypass_scan("user_absent");
`endif
  endtask

  task automatic test_abort;
    step(S_CIR, 1'b0);
    for (int i = 0; i < 4; i++) step(S_SIR, i == 3);
    n_checks++; if (bus.abort !== 1'b0) begin n_fail++; $display("FAIL abort_early: got %b expected 0", bus.abort); end
    step(S_UIR, 1'b0);
    n_checks++; if (bus.abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b expected 1", bus.abort); end
    n_checks++; if (bus.ir_value !== 4'b1000) begin n_fail++; $display("FAIL abort_ir_value: got %h expected 8", bus.ir_value); end
    step(S_RTI, 1'b0);
    n_checks++; if (bus.abort !== 1'b0) begin n_fail++; $display("FAIL abort_width: got %b expected 0", bus.abort); end
    bypass_scan("abort_dr");
  endtask

  task automatic test_pause_resume;
    logic [15:0] seq;
    step(S_TLR, 1'b0);
    n_checks++; if (bus.ir_value !== 4'b1110) begin n_fail++; $display("FAIL tlr_ir_value: got %h expected e", bus.ir_value); end
    step(S_CDR, 1'b0);
    for (int i = 0; i < 8; i++) begin step(S_SDR, 1'b0); seq[i] = tdo_s; end
    for (int i = 0; i < 3; i++) step(S_PAUSE, 1'b1);
    n_checks++; if (bus.dr_bit_count !== 6'd8) begin n_fail++; $display("FAIL pause_bit_count: got %0d expected 8", bus.dr_bit_count); end
    for (int i = 8; i < 16; i++) begin step(S_SDR, 1'b0); seq[i] = tdo_s; end
    n_checks++; if (seq !== 16'hAF01) begin n_fail++; $display("FAIL pause_resume_tdo: got %h expected af01", seq); end
  endtask

  task automatic test_saturation;
    step(S_CDR, 1'b0);
    for (int i = 0; i < 70; i++) step(S_SDR, 1'b0);
    step(S_RTI, 1'b0);
    n_checks++; if (bus.dr_bit_count !== 6'd63) begin n_fail++; $display("FAIL bit_count_saturate: got %0d expected 63", bus.dr_bit_count); end
  endtask

`ifdef USER_DR_EN
  task automatic test_user;
    logic [7:0] seq;
    logic [7:0] din;
    din = 8'hA5;
    load_ir(4'b0010);
    step(S_CDR, 1'b0);
    for (int i = 0; i < 8; i++) begin step(S_SDR, din[i]); seq[i] = tdo_s; end
    n_checks++; if (seq !== 8'h00) begin n_fail++; $display("FAIL user_first_capture: got %h expected 00", seq); end
    n_checks++; if (bus.user_update !== 1'b0) begin n_fail++; $display("FAIL user_update_early: got %b expected 0", bus.user_update); end
    step(S_UDR, 1'b0);
    n_checks++; if (bus.user_update !== 1'b1) begin n_fail++; $display("FAIL user_update_pulse: got %b expected 1", bus.user_update); end
    n_checks++; if (bus.user_reg !== 8'hA5) begin n_fail++; $display("FAIL user_reg_write: got %h expected a5", bus.user_reg); end
    step(S_RTI, 1'b0);
    n_checks++; if (bus.user_update !== 1'b0) begin n_fail++; $display("FAIL user_update_width: got %b expected 0", bus.user_update); end
    step(S_CDR, 1'b0);
    for (int i = 0; i < 8; i++) begin step(S_SDR, 1'b0); seq[i] = tdo_s; end
    step(S_RTI, 1'b0);
    n_checks++; if (seq !== 8'hA5) begin n_fail++; $display("FAIL user_readback: got %h expected a5", seq); end
    step(S_UDR, 1'b0);
    load_ir(4'b1111);
    step(S_CDR, 1'b0);
    step(S_UDR, 1'b0);
    n_checks++; if (bus.user_update !== 1'b0) begin n_fail++; $display("FAIL bypass_update_no_pulse: got %b expected 0", bus.user_update); end
    n_checks++; if (bus.user_reg !== 8'h00) begin n_fail++; $display("FAIL user_reg_after_zero_write: got %h expected 00", bus.user_reg); end
    load_ir(4'b0010);
    step(S_CDR, 1'b0);
    for (int i = 0; i < 8; i++) step(S_SDR, din[i]);
    step(S_UDR, 1'b0);
    step(S_RTI, 1'b0);
  endtask
`endif

  task automatic test_tlr_keeps_dr;
    load_ir(4'b1111);
    step(S_CDR, 1'b0);
    for (int i = 0; i < 3; i++) step(S_SDR, 1'b0);
    step(S_TLR, 1'b0);
    n_checks++; if (bus.ir_value !== 4'b1110) begin n_fail++; $display("FAIL tlr_resets_ir: got %h expected e", bus.ir_value); end
    n_checks++; if (bus.dr_bit_count !== 6'd3) begin n_fail++; $display("FAIL tlr_keeps_count: got %0d expected 3", bus.dr_bit_count); end
`ifdef USER_DR_EN
    n_checks++; if (bus.user_reg !== 8'hA5) begin n_fail++; $display("FAIL tlr_keeps_user_reg: got %h expected a5", bus.user_reg); end
`endif
  endtask

  task automatic test_reset_mid_shift;
    load_ir(4'b1111);
    step(S_TLR, 1'b0);
    step(S_CDR, 1'b0);
    for (int i = 0; i < 10; i++) step(S_SDR, 1'b1);
    bus.tap_state = S_SDR;
    #1;
    n_checks++; if (bus.tdo_en !== 1'b1) begin n_fail++; $display("FAIL mid_shift_tdo_en: got %b expected 1", bus.tdo_en); end
    trst = 1'b1;
    #1;
    n_checks++; if (bus.tdo !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tdo: got %b expected 0", bus.tdo); end
    n_checks++; if (bus.tdo_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tdo_en: got %b expected 0", bus.tdo_en); end
    n_checks++; if (bus.dr_bit_count !== 6'd0) begin n_fail++; $display("FAIL mid_reset_bit_count: got %0d expected 0", bus.dr_bit_count); end
    n_checks++; if (bus.ir_value !== 4'b1110) begin n_fail++; $display("FAIL mid_reset_ir_value: got %h expected e", bus.ir_value); end
`ifdef USER_DR_EN
    n_checks++; if (bus.user_reg !== 8'h00) begin n_fail++; $display("FAIL mid_reset_user_reg: got %h expected 00", bus.user_reg); end
`endif
    bus.tap_state = S_UDR;
    repeat (2) @(posedge tck);
    #1;
`ifdef USER_DR_EN
    n_checks++; if (bus.user_update !== 1'b0) begin n_fail++; $display("FAIL mid_reset_user_update: got %b expected 0", bus.user_update); end
`endif
    n_checks++; if (bus.abort !== 1'b0) begin n_fail++; $display("FAIL mid_reset_abort: got %b expected 0", bus.abort); end
    bus.tap_state = S_RTI;
    trst = 1'b0;
    step(S_RTI, 1'b0);
    // partial shift was discarded: IDCODE recaptures cleanly
    step(S_CDR, 1'b0);
    step(S_SDR, 1'b0);
    n_checks++; if (tdo_s !== 1'b1) begin n_fail++; $display("FAIL post_reset_idcode_lsb: got %b expected 1", tdo_s); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    trst          = 1'b1;
    bus.tap_state = S_RTI;
    bus.tdi       = 1'b0;
    test_reset();
    test_idcode();
    test_ir();
    test_bypass();
    test_abort();
    test_pause_resume();
    test_saturation();
`ifdef USER_DR_EN
    test_user();
`endif
    test_tlr_keeps_dr();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
